// File: rtl/mapper_mem_pkg.sv
// Shared types and helpers for the mapper memory scheduler and its request slots.
package mapper_mem_pkg;

  localparam int MEM_AW = 22;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

  typedef enum logic {
    PORT_PRG = 1'b0,
    PORT_CHR = 1'b1
  } port_id_t;

  // An access never reaches memory when the mapper blocks it or answers the read itself.
  function automatic logic access_is_local(input logic write, input logic allow,
                                           input logic bus_write);
    return !allow || (!write && bus_write);
  endfunction

endpackage

// File: rtl/mapper_mem_slot.sv
// One requester slot: captures a strobed access, resolves local accesses on the spot
// and holds memory-bound accesses until the scheduler completes them.
module mapper_mem_slot
  import mapper_mem_pkg::*;
#(
  parameter int AW = MEM_AW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          stb,
  input  logic          write,
  input  logic [AW-1:0] addr,
  input  logic          allow,
  input  logic [7:0]    din,
  input  logic          bus_write,
  input  logic [7:0]    bus_dout,
  input  logic          clear,
  output logic          pend,
  output logic          ovf,
  output logic          loc_done,
  output logic          loc_load,
  output logic [7:0]    loc_data,
  output logic          view_valid,
  output logic          view_we,
  output logic [AW-1:0] view_addr,
  output logic [7:0]    view_wdata
);

  logic          pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          is_local;
  logic          accept;

  always_comb begin
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    is_local = access_is_local(write, allow, bus_write);
    accept   = stb && !pend_q;
    loc_done = accept && is_local;
    loc_load = loc_done && !write && bus_write;
    loc_data = bus_dout;

    if (stb && pend_q) ovf_d = 1'b1;
    if (clear) pend_d = 1'b0;
    // Local accesses finish at the capture edge, so only memory-bound ones occupy the slot.
    if (accept && !is_local) begin
      pend_d  = 1'b1;
      we_d    = write;
      addr_d  = addr;
      wdata_d = din;
    end

    // The view bypasses the capture register so an idle scheduler can issue in the strobe cycle.
    view_valid = pend_q || (accept && !is_local);
    view_we    = pend_q ? we_q    : write;
    view_addr  = pend_q ? addr_q  : addr;
    view_wdata = pend_q ? wdata_q : din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign pend = pend_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/mapper_mem_sched.sv
// Memory scheduler: arbitrates translated PRG/CHR mapper accesses onto a single
// request/grant memory port and returns read data per requester.
module mapper_mem_sched
  import mapper_mem_pkg::*;
#(
  parameter int AW         = MEM_AW,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          prg_stb,
  input  logic          prg_write,
  input  logic [AW-1:0] prg_aout,
  input  logic          prg_allow,
  input  logic [7:0]    prg_din,
  input  logic          prg_bus_write,
  input  logic [7:0]    prg_bus_dout,
  output logic [7:0]    prg_rdata,
  output logic          prg_done,
  input  logic          chr_stb,
  input  logic          chr_write,
  input  logic [AW-1:0] chr_aout,
  input  logic          chr_allow,
  input  logic [7:0]    chr_din,
  output logic [7:0]    chr_rdata,
  output logic          chr_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
  output logic          ovf,
  output logic [1:0]    dbg_state
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  sched_state_t  state_q, state_d;
  port_id_t      port_q, port_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [7:0]    prg_rdata_q, prg_rdata_d;
  logic [7:0]    chr_rdata_q, chr_rdata_d;
  logic          prg_done_q, prg_done_d;
  logic          chr_done_q, chr_done_d;
  logic          prg_clear, chr_clear;
  logic          gnt_ev, pick_chr;

  logic          prg_pend, prg_ovf, prg_loc_done, prg_loc_load;
  logic [7:0]    prg_loc_data, prg_view_wdata;
  logic          prg_view_valid, prg_view_we;
  logic [AW-1:0] prg_view_addr;
  logic          chr_pend, chr_ovf, chr_loc_done, chr_loc_load;
  logic [7:0]    chr_loc_data, chr_view_wdata;
  logic          chr_view_valid, chr_view_we;
  logic [AW-1:0] chr_view_addr;

  mapper_mem_slot #(.AW(AW)) u_prg_slot (
    .clk        (clk),
    .resetn     (resetn),
    .stb        (prg_stb),
    .write      (prg_write),
    .addr       (prg_aout),
    .allow      (prg_allow),
    .din        (prg_din),
    .bus_write  (prg_bus_write),
    .bus_dout   (prg_bus_dout),
    .clear      (prg_clear),
    .pend       (prg_pend),
    .ovf        (prg_ovf),
    .loc_done   (prg_loc_done),
    .loc_load   (prg_loc_load),
    .loc_data   (prg_loc_data),
    .view_valid (prg_view_valid),
    .view_we    (prg_view_we),
    .view_addr  (prg_view_addr),
    .view_wdata (prg_view_wdata)
  );

  // CHR has no mapper register-read path, so its bus flag is tied low.
  mapper_mem_slot #(.AW(AW)) u_chr_slot (
    .clk        (clk),
    .resetn     (resetn),
    .stb        (chr_stb),
    .write      (chr_write),
    .addr       (chr_aout),
    .allow      (chr_allow),
    .din        (chr_din),
    .bus_write  (1'b0),
    .bus_dout   (8'h00),
    .clear      (chr_clear),
    .pend       (chr_pend),
    .ovf        (chr_ovf),
    .loc_done   (chr_loc_done),
    .loc_load   (chr_loc_load),
    .loc_data   (chr_loc_data),
    .view_valid (chr_view_valid),
    .view_we    (chr_view_we),
    .view_addr  (chr_view_addr),
    .view_wdata (chr_view_wdata)
  );

  // Handshake: mem_req with mem_we/mem_addr/mem_wdata is held stable from ISSUE entry
  // until the cycle mem_gnt is high; mem_rvalid is honoured only in WAIT.
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    starve_d    = starve_q;
    prg_rdata_d = prg_rdata_q;
    chr_rdata_d = chr_rdata_q;
    prg_done_d  = prg_loc_done;
    chr_done_d  = chr_loc_done;
    prg_clear   = 1'b0;
    chr_clear   = 1'b0;
    gnt_ev      = 1'b0;
    pick_chr    = 1'b0;

    if (prg_loc_load) prg_rdata_d = prg_loc_data;
    if (chr_loc_load) chr_rdata_d = chr_loc_data;

    case (state_q)
      IDLE: begin
        pick_chr = chr_view_valid && !(prg_view_valid && starve_q == SW'(STARVE_MAX));
        if (pick_chr) begin
          port_d      = PORT_CHR;
          mem_addr_d  = chr_view_addr;
          mem_we_d    = chr_view_we;
          mem_wdata_d = chr_view_wdata;
          state_d     = ISSUE;
        end else if (prg_view_valid) begin
          port_d      = PORT_PRG;
          mem_addr_d  = prg_view_addr;
          mem_we_d    = prg_view_we;
          mem_wdata_d = prg_view_wdata;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          gnt_ev = 1'b1;
          if (mem_we_q) begin
            state_d = IDLE;
            if (port_q == PORT_PRG) begin
              prg_done_d = 1'b1;
              prg_clear  = 1'b1;
            end else begin
              chr_done_d = 1'b1;
              chr_clear  = 1'b1;
            end
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          if (port_q == PORT_PRG) begin
            prg_rdata_d = mem_rdata;
            prg_done_d  = 1'b1;
            prg_clear   = 1'b1;
          end else begin
            chr_rdata_d = mem_rdata;
            chr_done_d  = 1'b1;
            chr_clear   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Count CHR grants that overtake a waiting PRG access.
    if (gnt_ev && port_q == PORT_PRG) begin
      starve_d = '0;
    end else if (!prg_pend) begin
      starve_d = '0;
    end else if (gnt_ev && port_q == PORT_CHR && starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      port_q      <= PORT_PRG;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      starve_q    <= '0;
      prg_rdata_q <= '0;
      chr_rdata_q <= '0;
      prg_done_q  <= 1'b0;
      chr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      starve_q    <= starve_d;
      prg_rdata_q <= prg_rdata_d;
      chr_rdata_q <= chr_rdata_d;
      prg_done_q  <= prg_done_d;
      chr_done_q  <= chr_done_d;
    end
  end

  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign prg_rdata = prg_rdata_q;
  assign chr_rdata = chr_rdata_q;
  assign prg_done  = prg_done_q;
  assign chr_done  = chr_done_q;
  assign busy      = prg_pend || chr_pend || (state_q != IDLE);
  assign ovf       = prg_ovf || chr_ovf;
  assign dbg_state = state_q;

endmodule
